// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: drives the single-transaction I2C wrapper for HDMI
// transmitter setup. It walks an external register table after reset or on
// start_init, then serves single host read/write requests between init runs.
// Optional macro I2C_INIT_VERIFY_EN: read back every init write and repeat the
// write until the readback matches (mismatches consume the retry budget).
module i2c_cfg_sequencer #(
  parameter logic [6:0] CHIP_ADDR      = 7'h39,
  parameter int         TABLE_LEN      = 32,
  parameter int         STARTUP_CYCLES = 1000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  output logic [5:0] tbl_idx,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_val,
  input  logic       host_req,
  input  logic       host_is_read,
  input  logic [7:0] host_reg,
  input  logic [7:0] host_val,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic [6:0] i2c_chip_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_value,
  output logic       i2c_enable,
  output logic       i2c_is_read,
  input  logic       i2c_done,
  input  logic [7:0] i2c_data,
  input  logic       i2c_ack_error,
  output logic       init_done,
  output logic       init_error
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_IDLE,
    S_HOST_ISSUE,
    S_HOST_WAIT
`ifdef I2C_INIT_VERIFY_EN
    ,
    S_VERIFY_ISSUE,
    S_VERIFY_WAIT
`endif
  } state_t;

  localparam logic [5:0]  LAST_IDX    = 6'(TABLE_LEN - 1);
  localparam logic [31:0] DELAY_LAST  = 32'(STARTUP_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  state_t      state, state_d;
  logic [31:0] delay_cnt, delay_d;
  logic [5:0]  idx_d;
  logic [2:0]  retry_cnt, retry_d;
  logic        armed, armed_d;
  logic        pending, pending_d;
  logic        enable_d, is_read_d;
  logic [7:0]  reg_d, value_d;
  logic        host_ack_d, host_err_d;
  logic [7:0]  host_rdata_d;
  logic        init_done_d, init_error_d;
  logic        entry_pass, entry_fail;
  logic        txn_done;

  // A transaction only counts as finished once done has been seen low after
  // the enable pulse; the stale done=1 from before the pulse is ignored.
  assign txn_done      = armed & i2c_done;
  assign i2c_chip_addr = CHIP_ADDR;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d      = state;
    delay_d      = delay_cnt;
    idx_d        = tbl_idx;
    retry_d      = retry_cnt;
    armed_d      = armed;
    pending_d    = pending;
    enable_d     = 1'b0;
    is_read_d    = i2c_is_read;
    reg_d        = i2c_reg_addr;
    value_d      = i2c_value;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata;
    host_err_d   = host_err;
    init_done_d  = init_done;
    init_error_d = init_error;
    entry_pass   = 1'b0;
    entry_fail   = 1'b0;

    if (start_init && state != S_IDLE && state != S_DELAY) begin
      pending_d = 1'b1;
    end

    case (state)
      S_DELAY: begin
        if (delay_cnt == DELAY_LAST) begin
          if (i2c_done) begin
            idx_d   = 6'd0;
            retry_d = 3'd0;
            state_d = S_INIT_ISSUE;
          end
        end else begin
          delay_d = delay_cnt + 32'd1;
        end
      end

      S_INIT_ISSUE: begin
        if (i2c_done) begin
          reg_d     = tbl_reg;
          value_d   = tbl_val;
          is_read_d = 1'b0;
          enable_d  = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_INIT_WAIT;
        end
      end

      S_INIT_WAIT: begin
        if (!i2c_done) begin
          armed_d = 1'b1;
        end else if (txn_done) begin
          if (i2c_ack_error) begin
            entry_fail = 1'b1;
          end else begin
`ifdef I2C_INIT_VERIFY_EN
            state_d = S_VERIFY_ISSUE;
`else
            entry_pass = 1'b1;
`endif
          end
        end
      end

`ifdef I2C_INIT_VERIFY_EN
      S_VERIFY_ISSUE: begin
        if (i2c_done) begin
          reg_d     = tbl_reg;
          value_d   = tbl_val;
          is_read_d = 1'b1;
          enable_d  = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_VERIFY_WAIT;
        end
      end

      S_VERIFY_WAIT: begin
        if (!i2c_done) begin
          armed_d = 1'b1;
        end else if (txn_done) begin
          if (i2c_ack_error || i2c_data != tbl_val) begin
            entry_fail = 1'b1;
          end else begin
            entry_pass = 1'b1;
          end
        end
      end
`endif

      S_IDLE: begin
        if (start_init || pending) begin
          pending_d    = 1'b0;
          init_done_d  = 1'b0;
          init_error_d = 1'b0;
          idx_d        = 6'd0;
          retry_d      = 3'd0;
          state_d      = S_INIT_ISSUE;
        end else if (host_req && !host_ack) begin
          state_d = S_HOST_ISSUE;
        end
      end

      S_HOST_ISSUE: begin
        if (i2c_done) begin
          reg_d     = host_reg;
          value_d   = host_val;
          is_read_d = host_is_read;
          enable_d  = 1'b1;
          armed_d   = 1'b0;
          state_d   = S_HOST_WAIT;
        end
      end

      S_HOST_WAIT: begin
        if (!i2c_done) begin
          armed_d = 1'b1;
        end else if (txn_done) begin
          host_rdata_d = i2c_data;
          host_err_d   = i2c_ack_error;
          host_ack_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_DELAY;
    endcase

    if (entry_fail) begin
      if (retry_cnt < RETRY_LIMIT) begin
        retry_d = retry_cnt + 3'd1;
        state_d = S_INIT_ISSUE;
      end else begin
        init_error_d = 1'b1;
        state_d      = S_IDLE;
      end
    end else if (entry_pass) begin
      if (tbl_idx == LAST_IDX) begin
        init_done_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        idx_d   = tbl_idx + 6'd1;
        retry_d = 3'd0;
        state_d = S_INIT_ISSUE;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_DELAY;
      delay_cnt    <= 32'd0;
      tbl_idx      <= 6'd0;
      retry_cnt    <= 3'd0;
      armed        <= 1'b0;
      pending      <= 1'b0;
      i2c_enable   <= 1'b0;
      i2c_is_read  <= 1'b0;
      i2c_reg_addr <= 8'd0;
      i2c_value    <= 8'd0;
      host_ack     <= 1'b0;
      host_rdata   <= 8'd0;
      host_err     <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
    end else begin
      state        <= state_d;
      delay_cnt    <= delay_d;
      tbl_idx      <= idx_d;
      retry_cnt    <= retry_d;
      armed        <= armed_d;
      pending      <= pending_d;
      i2c_enable   <= enable_d;
      i2c_is_read  <= is_read_d;
      i2c_reg_addr <= reg_d;
      i2c_value    <= value_d;
      host_ack     <= host_ack_d;
      host_rdata   <= host_rdata_d;
      host_err     <= host_err_d;
      init_done    <= init_done_d;
      init_error   <= init_error_d;
    end
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Sequences the I2C transaction wrapper (single-transaction, enable/done handshake) for the HDMI transmitter configuration.
- After reset or on a hot-plug request, walks an external register table and issues one write per entry.
- Between init runs, arbitrates single read/write requests from a host port (e.g. the ESP/menu control path).
- Init always has priority over the host.

Parameters:
CHIP_ADDR, 7'h39, 7-bit I2C address of the transmitter; driven on every transaction
TABLE_LEN, 32, number of table entries (1..64)
STARTUP_CYCLES, 1000, clk cycles to wait after reset before the first transaction (>=1)
MAX_RETRY, 3, retries per table entry after an ack error (0..7)

Ports:
clk  in  1  pixel clock, same clock as the I2C wrapper
reset  in  1  synchronous, active-low reset
start_init  in  1  one-cycle pulse; (re)run the table from index 0
tbl_idx  out  6  table index; the external table answers combinationally
tbl_reg  in  8  register address at tbl_idx
tbl_val  in  8  value at tbl_idx
host_req  in  1  level; held high until host_ack
host_is_read  in  1  host request is a read (stable while host_req)
host_reg  in  8  host register address
host_val  in  8  host write value
host_ack  out  1  one-cycle pulse when the host transaction ends
host_rdata  out  8  read data, valid with host_ack
host_err  out  1  ack error of the host transaction, valid with host_ack
i2c_chip_addr  out  7  to wrapper chip_addr
i2c_reg_addr  out  8  to wrapper reg_addr
i2c_value  out  8  to wrapper value
i2c_enable  out  1  to wrapper enable; one-cycle pulse
i2c_is_read  out  1  to wrapper is_read; held for the whole transaction
i2c_done  in  1  from wrapper done
i2c_data  in  8  from wrapper data
i2c_ack_error  in  1  from wrapper i2c_ack_error
init_done  out  1  table completed without fatal error
init_error  out  1  an entry exhausted its retries

Behaviour:
- Reset values:
  - state S_DELAY; delay counter 0; tbl_idx 0; retry counter 0.
  - i2c_enable, i2c_is_read, host_ack, host_err, init_done, init_error: 0.
  - host_rdata, i2c_reg_addr, i2c_value: 0.
  - i2c_chip_addr = CHIP_ADDR permanently.
- Reset mid-transaction: state returns to S_DELAY; the wrapper finishes on its own. S_DELAY also requires i2c_done=1 before leaving.
- States:
  - S_DELAY: count to STARTUP_CYCLES-1, then go to S_INIT_ISSUE with tbl_idx=0.
  - S_INIT_ISSUE:
    - Wait for i2c_done=1.
    - Then drive reg/value from tbl_reg/tbl_val, set i2c_is_read=0, pulse i2c_enable for 1 cycle, go to S_INIT_WAIT.
  - S_INIT_WAIT:
    - Wait for i2c_done=0 (armed flag), then i2c_done=1.
    - A done=1 before the armed flag is set is ignored.
    - On completion, sample i2c_ack_error:
      - Error and retry<MAX_RETRY: retry++, return to S_INIT_ISSUE with the same index.
      - Error and retry==MAX_RETRY: init_error=1, init_done stays 0, go to S_IDLE.
      - OK and tbl_idx==TABLE_LEN-1: init_done=1, go to S_IDLE.
      - OK otherwise: tbl_idx++, retry=0, go to S_INIT_ISSUE.
  - S_IDLE:
    - start_init (or pending flag): clear init_done/init_error, tbl_idx=0, go to S_INIT_ISSUE.
    - Else if host_req: go to S_HOST_ISSUE.
    - start_init wins when both occur in the same cycle.
  - S_HOST_ISSUE: as S_INIT_ISSUE, using host_reg/host_val/host_is_read.
  - S_HOST_WAIT:
    - Completion detected as in S_INIT_WAIT.
    - host_rdata<=i2c_data, host_err<=i2c_ack_error, host_ack pulse 1 cycle, go to S_IDLE.
    - No host retry.
- host_ack is followed by at least one idle cycle, so a still-high host_req is not re-served in the ack cycle.
- start_init in any state other than S_IDLE/S_DELAY:
  - Latched in a pending flag.
  - Served when the machine next reaches S_IDLE, after the current transaction completes.
  - A pending host request is not acked by the init run.
- start_init during S_DELAY is ignored (init follows anyway).
- i2c_is_read is held stable from the enable pulse until completion.
- Only one enable pulse per transaction.
- tbl_idx never exceeds TABLE_LEN-1.

Optional Feature:
I2C_INIT_VERIFY_EN
- Defined:
  - After each successful init write, issue a read of the same register (S_VERIFY_ISSUE/S_VERIFY_WAIT, i2c_is_read=1).
  - Compare i2c_data with tbl_val; a mismatch or ack error counts as one retry of the entry (write repeated).
  - The entry advances only on a match.
- Undefined: write-only init; verify states are not present.

Test Plan:
- Reset released, TABLE_LEN=4, wrapper model always acks: after STARTUP_CYCLES exactly 4 enable pulses, idx 0..3 in order, each only while done=1 -> init_done=1, init_error=0.
- Entry 2 acks error twice, MAX_RETRY=3: entry 2 issued 3 times, then entries 3.. continue -> init_done=1.
- Entry 1 always errors, MAX_RETRY=3: 4 attempts at idx1 -> init_error=1, init_done=0; then host read reg 8'h42 with model returning 8'hA5 -> host_ack 1 cycle, host_rdata=8'hA5, host_err=0.
- host_req held during init: no host transaction until init_done=1; then a single host write (reg 8'h98, val 8'h03) with i2c_is_read=0 -> host_ack.
- start_init pulsed during a host transaction: host completes with host_ack, then init restarts at idx0, init_done cleared until the rerun ends; reset asserted mid-init -> all outputs at reset values the next cycle.
- With I2C_INIT_VERIFY_EN, readback mismatch once on entry 0 -> write, read, write, read for entry 0, then entry 1.
